// File: rtl/bridge_if.sv
// Host bridge bus between tree nodes and leaf register blocks.
// Strobes are single-cycle; leaves return registered read data.
interface bridge_if;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        wr;
    logic        rd;

    modport leaf (
        input  addr,
        input  wr_data,
        input  wr,
        input  rd,
        output rd_data
    );

    modport parent (
        output addr,
        output wr_data,
        output wr,
        output rd,
        input  rd_data
    );
endinterface

// File: rtl/bridge_write_fifo.sv
// Bridge leaf: DATA writes feed a FIFO drained as a valid/ready stream.
// STATUS/DROPS expose level and overflow statistics on bridge reads.
module bridge_write_fifo #(
    parameter int          data_width = 32,
    parameter int          depth      = 16,
    parameter logic [31:0] base_addr  = 32'h0000_0000,
    parameter logic [31:0] addr_mask  = 32'hFFFF_FFF0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    bridge_if.leaf                bridge,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    input  logic                  out_ready
);

    localparam int pw = $clog2(depth);
    localparam int lw = pw + 1;

    logic [data_width-1:0] mem [depth];
    logic [pw-1:0]         wr_ptr;
    logic [pw-1:0]         rd_ptr;
    logic [lw-1:0]         level;
    logic                  sticky;
    logic [15:0]           drops;

    logic        hit;
    logic [1:0]  offset;
    logic        data_wr;
    logic        ctrl_wr;
    logic        flush;
    logic        clr;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;
    logic [31:0] status;

    assign hit     = (bridge.addr & addr_mask) == base_addr;
    assign offset  = bridge.addr[3:2];
    assign data_wr = bridge.wr && hit && (offset == 2'd0);
    assign ctrl_wr = bridge.wr && hit && (offset == 2'd2);
    assign flush   = ctrl_wr && bridge.wr_data[0];
    assign clr     = ctrl_wr && bridge.wr_data[1];

    assign full      = level == lw'(depth);
    assign out_valid = level != '0;
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a word when the head leaves this cycle
    assign push      = data_wr && (!full || pop);
    assign drop      = data_wr && full && !pop;

    assign out_data = out_valid ? mem[rd_ptr] : '0;

    assign status = {sticky, 13'b0, level == '0, full, 16'(level)};

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bridge.wr_data[data_width-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + pw'(1);
            if (pop)
                rd_ptr <= rd_ptr + pw'(1);
            if (push && !pop)
                level <= level + lw'(1);
            else if (pop && !push)
                level <= level - lw'(1);
        end
    end

    // A drop in the clearing cycle survives the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky <= 1'b0;
            drops  <= '0;
        end else if (clr) begin
            sticky <= drop;
            drops  <= {15'b0, drop};
        end else if (drop) begin
            sticky <= 1'b1;
            if (drops != 16'hFFFF)
                drops <= drops + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bridge.rd_data <= '0;
        end else if (bridge.rd && hit) begin
            unique case (offset)
                2'd1:    bridge.rd_data <= status;
                2'd3:    bridge.rd_data <= {16'b0, drops};
                default: bridge.rd_data <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_write_fifo.sv
// Scoreboard bench for bridge_write_fifo: stream words checked in order,
// register reads checked against a small model of level/sticky/drops.
module tb_bridge_write_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;

    bridge_if bus ();

    bridge_write_fifo dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bridge    (bus.leaf),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    logic [31:0] q [$];
    logic        m_sticky = 1'b0;
    logic [15:0] m_drops = '0;
    int          errors = 0;
    int          checks = 0;

    localparam logic [31:0] a_data = 32'h0;
    localparam logic [31:0] a_stat = 32'h4;
    localparam logic [31:0] a_ctrl = 32'h8;
    localparam logic [31:0] a_drop = 32'hC;
    localparam logic [31:0] a_miss = 32'h100;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int lvl;
        lvl = q.size();
        return {m_sticky, 13'b0, lvl == 0, lvl == 16, 16'(lvl)};
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            chk("valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            if (out_valid && out_ready) begin
                if (q.size() == 0)
                    chk("sb_underflow", out_data, 32'hDEAD_BEEF);
                else
                    chk("sb_data", out_data, q.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        logic hit;
        logic do_push;
        logic do_drop;
        hit     = (a & 32'hFFFF_FFF0) == 32'h0;
        do_push = 1'b0;
        do_drop = 1'b0;
        if (hit && a[3:2] == 2'd0) begin
            if (q.size() < 16 || out_ready)
                do_push = 1'b1;
            else
                do_drop = 1'b1;
        end
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr      = 1'b1;
        @(posedge clk);
        #1 bus.wr = 1'b0;
        if (do_push)
            q.push_back(d);
        if (do_drop) begin
            m_sticky = 1'b1;
            if (m_drops != 16'hFFFF)
                m_drops++;
        end
        if (hit && a[3:2] == 2'd2) begin
            if (d[0])
                q.delete();
            if (d[1]) begin
                m_sticky = 1'b0;
                m_drops  = '0;
            end
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.rd   = 1'b1;
        @(posedge clk);
        #1 bus.rd = 1'b0;
        d = bus.rd_data;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!out_valid && q.size() == 0)
                break;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        chk("drain_valid", {31'b0, out_valid}, 32'h0);
        chk("drain_left", q.size(), 32'h0);
        chk("drain_data", out_data, 32'h0);
    endtask

    logic [31:0] rv;
    logic [31:0] held;
    logic [31:0] es;

    initial begin
        bus.addr    = '0;
        bus.wr_data = '0;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_rd", bus.rd_data, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus_read(a_stat, rv);
        chk("rst_status", rv, 32'h0002_0000);
        bus_read(a_drop, rv);
        chk("rst_drops", rv, 32'h0);

        bus_write(a_data, 32'hA5);
        chk("wr_valid", {31'b0, out_valid}, 32'h1);
        chk("wr_data", out_data, 32'hA5);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pop_valid", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b0;

        for (int i = 1; i <= 16; i++)
            bus_write(a_data, 32'(i));
        bus_read(a_stat, rv);
        chk("full_status", rv, 32'h0001_0010);
        bus_write(a_data, 32'h99);
        bus_read(a_stat, rv);
        chk("ovf_status", rv, 32'h8001_0010);
        bus_read(a_drop, rv);
        chk("ovf_drops", rv, 32'h1);

        out_ready = 1'b1;
        bus_write(a_data, 32'h77);
        out_ready = 1'b0;
        bus_read(a_stat, rv);
        chk("pushpop_status", rv, exp_status());
        chk("pushpop_level", {16'b0, rv[15:0]}, 32'h10);
        chk("pushpop_drops_m", {16'b0, m_drops}, 32'h1);
        drain();

        for (int i = 0; i < 5; i++)
            bus_write(a_data, 32'h100 + 32'(i));
        out_ready = 1'b1;
        bus_write(a_ctrl, 32'h1);
        out_ready = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'h0);
        bus_read(a_stat, rv);
        chk("flush_status", rv, exp_status());
        chk("flush_empty", {30'b0, rv[17:16]}, 32'h2);

        for (int i = 0; i < 19; i++)
            bus_write(a_data, 32'h200 + 32'(i));
        bus_read(a_drop, rv);
        chk("drops_4", rv, {16'b0, m_drops});
        chk("drops_4m", {16'b0, m_drops}, 32'h4);
        bus_write(a_ctrl, 32'h2);
        bus_read(a_drop, rv);
        chk("clr_drops", rv, 32'h0);
        bus_read(a_stat, rv);
        chk("clr_status", rv, 32'h0001_0010);
        held = rv;
        bus_read(a_miss, rv);
        chk("miss_rd", rv, held);
        bus_write(a_miss, 32'h55);
        bus_write(a_miss | 32'h4, 32'h56);
        bus_read(a_stat, rv);
        chk("miss_wr", rv, held);
        drain();

        for (int i = 0; i < 3; i++)
            bus_write(a_data, 32'h300 + 32'(i));
        bus_read(a_stat, rv);
        es = exp_status();
        chk("pre_rst_status", rv, es);
        @(posedge clk);
        #3 reset_n = 1'b0;
        q.delete();
        m_sticky = 1'b0;
        m_drops  = '0;
        #1;
        chk("async_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rd", bus.rd_data, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus_read(a_stat, rv);
        chk("post_rst_status", rv, 32'h0002_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
